// File: rtl/audio_pkg.sv
// Shared audio constants and the I2S slot-to-bit mapping used by the serializer.
package audio_pkg;
  localparam int AUDIO_W      = 16;
  localparam int SLOTS_PER_CH = 32;
  localparam int I2S_DELAY    = 1;
  localparam int SLOT_W       = $clog2(SLOTS_PER_CH);
  localparam int BIT_W        = $clog2(AUDIO_W);

  // Data bit carried in a given slot of one channel; MSB follows the delay slot,
  // everything outside the sample window is padding zero.
  function automatic logic i2s_bit(input logic [AUDIO_W-1:0] smp,
                                   input logic [SLOT_W-1:0]  slot);
    int               k;
    logic [BIT_W-1:0] bi;
    k  = int'(slot) - I2S_DELAY;
    bi = BIT_W'(AUDIO_W - 1 - k);
    return (k >= 0 && k < AUDIO_W) ? smp[bi] : 1'b0;
  endfunction
endpackage

// File: rtl/i2s_audio_tx_if.sv
// Sample inputs from the mixer and the I2S pins toward the DAC.
interface i2s_audio_tx_if;
  import audio_pkg::*;

  logic [AUDIO_W-1:0] audio_in_left;
  logic [AUDIO_W-1:0] audio_in_right;
  logic               mute;
  logic               audio_mclk;
  logic               audio_sck;
  logic               audio_lrck;
  logic               audio_sdin;
  logic               sample_tick;

  modport master (
    output audio_in_left, audio_in_right, mute,
    input  audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_tick
  );

  modport slave (
    input  audio_in_left, audio_in_right, mute,
    output audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_tick
  );
endinterface

// File: rtl/i2s_clk_gen.sv
// Free-running frame counter producing registered MCLK/SCK/LRCK and the capture strobe.
// Outputs are registered from the incremented count so they track the count held this cycle.
module i2s_clk_gen
  import audio_pkg::*;
#(
  parameter int SCK_DIV_LOG2  = 3,
  parameter int MCLK_DIV_LOG2 = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mclk,
  output logic              sck,
  output logic              lrck,
  output logic              capture,
  output logic [SLOT_W-1:0] slot_nxt,
  output logic              lrck_nxt
);
  localparam int F = SCK_DIV_LOG2 + 6;

  logic [F-1:0] div_cnt;
  logic [F-1:0] cnt_nxt;

  assign cnt_nxt  = div_cnt + F'(1);
  assign slot_nxt = cnt_nxt[F-2:SCK_DIV_LOG2];
  assign lrck_nxt = cnt_nxt[F-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      mclk    <= 1'b0;
      sck     <= 1'b0;
      lrck    <= 1'b0;
      capture <= 1'b0;
    end else begin
      div_cnt <= cnt_nxt;
      mclk    <= cnt_nxt[MCLK_DIV_LOG2];
      sck     <= cnt_nxt[SCK_DIV_LOG2-1];
      lrck    <= cnt_nxt[F-1];
      capture <= (cnt_nxt == '1);
    end
  end
endmodule

// File: rtl/i2s_audio_tx.sv
// Stereo I2S transmitter: captures one L/R pair per frame into shadow registers
// and shifts them out MSB-first with the one-slot I2S delay.
module i2s_audio_tx
  import audio_pkg::*;
#(
  parameter int SCK_DIV_LOG2  = 3,
  parameter int MCLK_DIV_LOG2 = 1
) (
  input logic           clk,
  input logic           rst,
  i2s_audio_tx_if.slave bus
);
  logic               mclk;
  logic               sck;
  logic               lrck;
  logic               capture;
  logic [SLOT_W-1:0]  slot_nxt;
  logic               lrck_nxt;
  logic [AUDIO_W-1:0] shadow_l;
  logic [AUDIO_W-1:0] shadow_r;
  logic               sdin;

  i2s_clk_gen #(
    .SCK_DIV_LOG2  (SCK_DIV_LOG2),
    .MCLK_DIV_LOG2 (MCLK_DIV_LOG2)
  ) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .mclk     (mclk),
    .sck      (sck),
    .lrck     (lrck),
    .capture  (capture),
    .slot_nxt (slot_nxt),
    .lrck_nxt (lrck_nxt)
  );

  // sdin is computed from the next slot so it moves exactly with SCK's falling edge.
  // The capture cycle always leads into slot 0, so the stale shadow is never shifted.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_l <= '0;
      shadow_r <= '0;
      sdin     <= 1'b0;
    end else begin
      if (capture) begin
        shadow_l <= bus.mute ? '0 : bus.audio_in_left;
        shadow_r <= bus.mute ? '0 : bus.audio_in_right;
      end
      sdin <= i2s_bit(lrck_nxt ? shadow_r : shadow_l, slot_nxt);
    end
  end

  assign bus.audio_mclk  = mclk;
  assign bus.audio_sck   = sck;
  assign bus.audio_lrck  = lrck;
  assign bus.audio_sdin  = sdin;
  assign bus.sample_tick = capture;
endmodule

// File: tb/tb_i2s_audio_tx.sv
// Bench for i2s_audio_tx: frame-level reference model plus directed bit-stream checks.
module tb_i2s_audio_tx;
  localparam int FRAME = 512;
  localparam int HALF  = 256;

  logic clk;
  logic rst;
  i2s_audio_tx_if bus ();

  i2s_audio_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model: position in the frame plus the words being sent this frame.
  int          mt = 0;
  logic [15:0] tx_l = '0;
  logic [15:0] tx_r = '0;

  always @(posedge clk) begin
    if (rst) begin
      mt   <= 0;
      tx_l <= '0;
      tx_r <= '0;
    end else begin
      if (mt % FRAME == FRAME - 1) begin
        tx_l <= bus.mute ? 16'h0 : bus.audio_in_left;
        tx_r <= bus.mute ? 16'h0 : bus.audio_in_right;
      end
      mt <= mt + 1;
    end
  end

  function automatic logic [4:0] exp_out();
    int          n;
    int          slot;
    logic [15:0] w;
    logic        d;
    n    = mt % FRAME;
    slot = (n % HALF) / 8;
    w    = (n >= HALF) ? tx_r : tx_l;
    d    = (slot >= 1 && slot <= 16) ? w[4'(16 - slot)] : 1'b0;
    return {((n / 2) % 2) == 1, ((n / 4) % 2) == 1, n >= HALF, d, n == FRAME - 1};
  endfunction

  logic [4:0] obs;
  assign obs = {bus.audio_mclk, bus.audio_sck, bus.audio_lrck, bus.audio_sdin, bus.sample_tick};

  task automatic do_reset(input logic [15:0] l, input logic [15:0] r);
    rst                = 1'b1;
    bus.audio_in_left  = l;
    bus.audio_in_right = r;
    bus.mute           = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int first_tick, ticks, mrise, srise, ltog;
    logic [4:0] prev;
    rst                = 1'b1;
    bus.audio_in_left  = 16'($urandom);
    bus.audio_in_right = 16'($urandom);
    bus.mute           = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (obs !== 5'b0) $display("FAIL reset_outputs: got %b want 00000", obs);
    else pass_cnt++;
    rst = 1'b0;
    first_tick = -1; ticks = 0; mrise = 0; srise = 0; ltog = 0; prev = obs;
    for (int i = 0; i < 1100; i++) begin
      if (i > 0) @(negedge clk);
      chk_cnt++;
      if (obs !== exp_out()) $display("FAIL reset_run cycle %0d: got %b want %b", i, obs, exp_out());
      else pass_cnt++;
      if (i > 0 && i <= FRAME) begin
        if (obs[4] && !prev[4]) mrise++;
        if (obs[3] && !prev[3]) srise++;
        if (obs[2] != prev[2]) ltog++;
      end
      if (obs[0]) begin
        ticks++;
        if (first_tick < 0) first_tick = i;
      end
      prev = obs;
    end
    chk_cnt++;
    if (first_tick != 511) $display("FAIL first_tick: got %0d want 511", first_tick);
    else pass_cnt++;
    chk_cnt++;
    if (ticks != 2) $display("FAIL tick_count: got %0d want 2", ticks);
    else pass_cnt++;
    chk_cnt++;
    if (mrise != 128) $display("FAIL mclk_period: got %0d rises want 128", mrise);
    else pass_cnt++;
    chk_cnt++;
    if (srise != 64) $display("FAIL sck_period: got %0d rises want 64", srise);
    else pass_cnt++;
    chk_cnt++;
    if (ltog != 2) $display("FAIL lrck_period: got %0d toggles want 2", ltog);
    else pass_cnt++;
  endtask

  // Samples sdin mid-slot during the second frame and compares whole channel streams.
  task automatic test_pattern(input string name, input logic [15:0] l, input logic [15:0] r);
    logic [31:0] lbits, rbits, lexp, rexp;
    int n;
    lbits = '0; rbits = '0;
    do_reset(l, r);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (i > 0) @(negedge clk);
      chk_cnt++;
      if (obs !== exp_out()) $display("FAIL %s cycle %0d: got %b want %b", name, i, obs, exp_out());
      else pass_cnt++;
      n = i % FRAME;
      if (i >= FRAME && n % 8 == 4) begin
        if (n < HALF) lbits = {lbits[30:0], bus.audio_sdin};
        else          rbits = {rbits[30:0], bus.audio_sdin};
      end
    end
    lexp = {1'b0, l, 15'b0};
    rexp = {1'b0, r, 15'b0};
    chk_cnt++;
    if (lbits !== lexp) $display("FAIL %s_left_stream: got %b want %b", name, lbits, lexp);
    else pass_cnt++;
    chk_cnt++;
    if (rbits !== rexp) $display("FAIL %s_right_stream: got %b want %b", name, rbits, rexp);
    else pass_cnt++;
  endtask

  task automatic test_mute();
    int high1, high2;
    high1 = 0; high2 = 0;
    do_reset(16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (i > 0) @(negedge clk);
      chk_cnt++;
      if (obs !== exp_out()) $display("FAIL mute cycle %0d: got %b want %b", i, obs, exp_out());
      else pass_cnt++;
      if (i >= FRAME && i < 2 * FRAME && bus.audio_sdin) high1++;
      if (i >= 2 * FRAME && bus.audio_sdin) high2++;
      bus.mute = (i == 300 || i == 510 || i == 700 || i == 2 * FRAME - 1);
    end
    chk_cnt++;
    if (high1 != 256) $display("FAIL mute_outside_capture: got %0d high cycles want 256", high1);
    else pass_cnt++;
    chk_cnt++;
    if (high2 != 0) $display("FAIL mute_at_capture: got %0d high cycles want 0", high2);
    else pass_cnt++;
    bus.mute = 1'b0;
  endtask

  task automatic test_hold();
    logic [31:0] b1, b2;
    int n;
    b1 = '0; b2 = '0;
    do_reset(16'h0001, 16'h0001);
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (i > 0) @(negedge clk);
      chk_cnt++;
      if (obs !== exp_out()) $display("FAIL hold cycle %0d: got %b want %b", i, obs, exp_out());
      else pass_cnt++;
      n = i % FRAME;
      if (n % 8 == 4 && n < HALF) begin
        if (i >= FRAME && i < 2 * FRAME) b1 = {b1[30:0], bus.audio_sdin};
        if (i >= 2 * FRAME)              b2 = {b2[30:0], bus.audio_sdin};
      end
      if (i == FRAME + 100) begin
        bus.audio_in_left  = 16'hFFFE;
        bus.audio_in_right = 16'hFFFE;
      end
    end
    chk_cnt++;
    if (b1 !== {1'b0, 16'h0001, 15'b0}) $display("FAIL hold_current_frame: got %b", b1);
    else pass_cnt++;
    chk_cnt++;
    if (b2 !== {1'b0, 16'hFFFE, 15'b0}) $display("FAIL hold_next_frame: got %b", b2);
    else pass_cnt++;
  endtask

  task automatic test_random();
    do_reset(16'($urandom), 16'($urandom));
    for (int i = 0; i < 6 * FRAME; i++) begin
      if (i > 0) @(negedge clk);
      chk_cnt++;
      if (obs !== exp_out()) $display("FAIL random cycle %0d: got %b want %b", i, obs, exp_out());
      else pass_cnt++;
      if ($urandom_range(0, 149) == 0) begin
        bus.audio_in_left  = 16'($urandom);
        bus.audio_in_right = 16'($urandom);
      end
      bus.mute = ($urandom_range(0, 15) == 0) || (i == 4 * FRAME - 1);
    end
    bus.mute = 1'b0;
  endtask

  task automatic test_midreset();
    int first_tick;
    first_tick = -1;
    do_reset(16'($urandom) | 16'h8001, 16'($urandom) | 16'h8001);
    for (int i = 0; i < FRAME + 300; i++) begin
      if (i > 0) @(negedge clk);
      chk_cnt++;
      if (obs !== exp_out()) $display("FAIL midreset_pre cycle %0d: got %b want %b", i, obs, exp_out());
      else pass_cnt++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (obs !== 5'b0) $display("FAIL midreset_outputs: got %b want 00000", obs);
    else pass_cnt++;
    rst = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (i > 0) @(negedge clk);
      chk_cnt++;
      if (obs !== exp_out()) $display("FAIL midreset_post cycle %0d: got %b want %b", i, obs, exp_out());
      else pass_cnt++;
      if (obs[0] && first_tick < 0) first_tick = i;
    end
    chk_cnt++;
    if (first_tick != 511) $display("FAIL midreset_first_tick: got %0d want 511", first_tick);
    else pass_cnt++;
  endtask

  initial begin
    rst                = 1'b1;
    bus.audio_in_left  = '0;
    bus.audio_in_right = '0;
    bus.mute           = 1'b0;
    @(negedge clk);
    test_reset();
    test_pattern("pattern_a5c3", 16'hA5C3, 16'h1234);
    test_pattern("pattern_edges", 16'h8000, 16'h7FFF);
    test_mute();
    test_hold();
    test_random();
    test_midreset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
